// File: rtl/commit_trace_queue_if.sv
// Retire-record bus between the writeback stage, the commit trace queue and
// the difftest/trace consumer.
interface commit_trace_queue_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_pc;
  logic [31:0] wb_inst;
  logic [63:0] wb_dnpc;
  logic        wb_skip;
  logic        wb_ebreak;

  logic        cm_valid;
  logic        cm_ready;
  logic [63:0] cm_pc;
  logic [31:0] cm_inst;
  logic [63:0] cm_dnpc;
  logic        cm_skip;
  logic        cm_is_break;

  // Environment side: WB producer plus trace consumer
  modport master (
    output wb_valid, wb_pc, wb_inst, wb_dnpc, wb_skip, wb_ebreak, cm_ready,
    input  wb_ready, cm_valid, cm_pc, cm_inst, cm_dnpc, cm_skip, cm_is_break
  );

  // Queue side
  modport slave (
    input  wb_valid, wb_pc, wb_inst, wb_dnpc, wb_skip, wb_ebreak, cm_ready,
    output wb_ready, cm_valid, cm_pc, cm_inst, cm_dnpc, cm_skip, cm_is_break
  );
endinterface

// File: rtl/commit_trace_queue.sv
// Retire-record FIFO feeding the difftest/trace consumer; sequences a sticky
// halt once the ebreak record has been delivered.
module commit_trace_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  commit_trace_queue_if.slave  bus,
  output logic                 halt,
  output logic [63:0]          commit_cnt,
  output logic [PTR_W:0]       occupancy
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] dnpc;
    logic        skip;
    logic        ebreak;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  state_t         state;
  state_t         state_nx;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  assign push = bus.wb_valid & bus.wb_ready;
  assign pop  = bus.cm_valid & bus.cm_ready;

  assign bus.cm_valid    = !empty;
  assign bus.cm_pc       = head.pc;
  assign bus.cm_inst     = head.inst;
  assign bus.cm_dnpc     = head.dnpc;
  assign bus.cm_skip     = head.skip;
  assign bus.cm_is_break = head.ebreak;

  assign halt      = (state == HALT);
  assign occupancy = wr_ptr - rd_ptr;

  always_comb begin
    state_nx     = state;
    bus.wb_ready = 1'b0;
    case (state)
      RUN: begin
        // No pass-through: a pop while full never frees the slot this cycle
        bus.wb_ready = !full;
        if (push && bus.wb_ebreak) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && head.ebreak) state_nx = HALT;
      end
      HALT: begin
        state_nx = HALT;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_cnt <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        commit_cnt <= commit_cnt + 64'd1;
      end
    end
  end

  // Record storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= '{
        pc:     bus.wb_pc,
        inst:   bus.wb_inst,
        dnpc:   bus.wb_dnpc,
        skip:   bus.wb_skip,
        ebreak: bus.wb_ebreak
      };
    end
  end

endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed and randomized bench for commit_trace_queue against a queue-based
// reference model of the retire stream.
module tb_commit_trace_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] dnpc;
    logic        skip;
    logic        ebreak;
  } rec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           halt;
  logic [63:0]    commit_cnt;
  logic [PTR_W:0] occupancy;

  commit_trace_queue_if bus ();

  commit_trace_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .halt       (halt),
    .commit_cnt (commit_cnt),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  rec_t        m[$];
  rec_t        tx[$];
  logic        m_drain;
  logic        m_halt;
  logic [63:0] m_cnt;
  logic        m_pushed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [63:0] pc, input logic [31:0] inst,
                              input logic skip, input logic ebreak);
    rec_t r;
    r.pc = pc; r.inst = inst; r.dnpc = pc + 64'd4; r.skip = skip; r.ebreak = ebreak;
    return r;
  endfunction

  task automatic model_clear();
    m.delete();
    tx.delete();
    m_drain  = 1'b0;
    m_halt   = 1'b0;
    m_cnt    = '0;
    m_pushed = 1'b0;
  endtask

  // One clock: check outputs against the model, then advance the model
  task automatic cycle();
    logic exp_ready;
    logic do_pop;
    rec_t r;
    rec_t h;
    exp_ready = !m_drain && !m_halt && (m.size() < DEPTH);
    chk("wb_ready", 64'(bus.wb_ready), 64'(exp_ready));
    chk("cm_valid", 64'(bus.cm_valid), 64'(m.size() > 0));
    chk("occupancy", 64'(occupancy), 64'(m.size()));
    chk("halt", 64'(halt), 64'(m_halt));
    chk("commit_cnt", commit_cnt, m_cnt);
    if (m.size() > 0) begin
      chk("cm_pc", bus.cm_pc, m[0].pc);
      chk("cm_inst", 64'(bus.cm_inst), 64'(m[0].inst));
      chk("cm_dnpc", bus.cm_dnpc, m[0].dnpc);
      chk("cm_skip", 64'(bus.cm_skip), 64'(m[0].skip));
      chk("cm_is_break", 64'(bus.cm_is_break), 64'(m[0].ebreak));
    end
    m_pushed = bus.wb_valid && exp_ready;
    do_pop   = (m.size() > 0) && bus.cm_ready;
    r.pc = bus.wb_pc; r.inst = bus.wb_inst; r.dnpc = bus.wb_dnpc;
    r.skip = bus.wb_skip; r.ebreak = bus.wb_ebreak;
    @(posedge clk);
    if (do_pop) begin
      h = m.pop_front();
      m_cnt = m_cnt + 64'd1;
      if (h.ebreak) begin
        m_halt  = 1'b1;
        m_drain = 1'b0;
      end
    end
    if (m_pushed) begin
      m.push_back(r);
      if (r.ebreak) m_drain = 1'b1;
    end
    #1;
  endtask

  // rmode: 0 stall 6 cycles then ready, 1 never ready, 2 pattern 1,0,1,1,
  //        3 random valid/ready, 4 always ready
  task automatic run(input int unsigned ncyc, input int unsigned rmode);
    logic v;
    for (int unsigned c = 0; c < ncyc; c++) begin
      v = (tx.size() > 0);
      if (rmode == 3) v = v && ($urandom_range(0, 3) != 0);
      bus.wb_valid = v;
      if (v) begin
        bus.wb_pc = tx[0].pc; bus.wb_inst = tx[0].inst; bus.wb_dnpc = tx[0].dnpc;
        bus.wb_skip = tx[0].skip; bus.wb_ebreak = tx[0].ebreak;
      end else begin
        bus.wb_pc = {$urandom, $urandom}; bus.wb_inst = $urandom;
        bus.wb_dnpc = {$urandom, $urandom};
        bus.wb_skip = 1'($urandom); bus.wb_ebreak = 1'($urandom);
      end
      case (rmode)
        0:       bus.cm_ready = (c >= 6);
        1:       bus.cm_ready = 1'b0;
        2:       bus.cm_ready = ((c % 4) != 1);
        3:       bus.cm_ready = 1'($urandom);
        default: bus.cm_ready = 1'b1;
      endcase
      cycle();
      if (m_pushed) void'(tx.pop_front());
    end
    bus.wb_valid = 1'b0;
    bus.cm_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #2;
    chk("rst_cm_valid", 64'(bus.cm_valid), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_wb_ready", 64'(bus.wb_ready), 64'd1);
    chk("rst_commit_cnt", commit_cnt, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wb_valid = 1'b0; bus.wb_pc = '0; bus.wb_inst = '0; bus.wb_dnpc = '0;
    bus.wb_skip = 1'b0; bus.wb_ebreak = 1'b0; bus.cm_ready = 1'b0;

    // Reset state
    do_reset();

    // Single record latency
    tx.push_back(mk(64'h8000_0000, 32'h0000_0413, 1'b0, 1'b0));
    run(3, 4);
    chk("single_cnt", commit_cnt, 64'd1);
    chk("single_occ", 64'(occupancy), 64'd0);

    // Fill and backpressure
    for (int unsigned k = 0; k < 5; k++)
      tx.push_back(mk(64'h8000_0000 + 64'(4 * k), $urandom, 1'b0, 1'b0));
    run(5, 0);
    chk("fill_occ", 64'(occupancy), 64'd4);
    chk("fill_held", 64'(tx.size()), 64'd1);
    run(12, 0);
    chk("fill_all_sent", 64'(tx.size()), 64'd0);
    chk("fill_cnt", commit_cnt, 64'd6);

    // Wrap-around with concurrent push and pop
    do_reset();
    for (int unsigned k = 0; k < 20; k++)
      tx.push_back(mk(64'h8000_1000 + 64'(4 * k), $urandom, 1'($urandom), 1'b0));
    run(40, 2);
    chk("wrap_all_sent", 64'(tx.size()), 64'd0);
    chk("wrap_cnt", commit_cnt, 64'd20);

    // Skip flag passthrough
    tx.push_back(mk(64'h8000_00fc, 32'h0000_0013, 1'b0, 1'b0));
    tx.push_back(mk(64'h8000_0100, 32'h0000_3503, 1'b1, 1'b0));
    tx.push_back(mk(64'h8000_0104, 32'h0000_0013, 1'b0, 1'b0));
    run(6, 4);

    // Randomized traffic
    do_reset();
    for (int unsigned k = 0; k < 40; k++) begin
      rec_t r;
      r.pc = {$urandom, $urandom}; r.inst = $urandom; r.dnpc = {$urandom, $urandom};
      r.skip = 1'($urandom); r.ebreak = 1'b0;
      tx.push_back(r);
    end
    run(300, 3);
    run(10, 4);
    chk("rand_all_sent", 64'(tx.size()), 64'd0);
    chk("rand_cnt", commit_cnt, 64'd40);

    // Ebreak drain and halt
    do_reset();
    tx.push_back(mk(64'h8000_0008, 32'h0000_0013, 1'b0, 1'b0));
    tx.push_back(mk(64'h8000_000c, 32'h0000_0013, 1'b0, 1'b0));
    tx.push_back(mk(64'h8000_0010, 32'h0010_0073, 1'b0, 1'b1));
    tx.push_back(mk(64'h8000_0014, 32'h0000_0013, 1'b0, 1'b0));
    run(15, 0);
    chk("ebreak_4th_held", 64'(tx.size()), 64'd1);
    chk("ebreak_halt", 64'(halt), 64'd1);
    chk("ebreak_cnt", commit_cnt, 64'd3);
    chk("ebreak_wb_ready", 64'(bus.wb_ready), 64'd0);

    // Reset mid-operation while draining
    do_reset();
    tx.push_back(mk(64'h8000_0200, 32'h0000_0013, 1'b0, 1'b0));
    tx.push_back(mk(64'h8000_0204, 32'h0000_0013, 1'b0, 1'b0));
    tx.push_back(mk(64'h8000_0208, 32'h0010_0073, 1'b0, 1'b1));
    run(4, 1);
    chk("mid_occ_before", 64'(occupancy), 64'd3);
    chk("mid_wb_ready_before", 64'(bus.wb_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid_cm_valid", 64'(bus.cm_valid), 64'd0);
    chk("mid_halt", 64'(halt), 64'd0);
    chk("mid_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_wb_ready_after", 64'(bus.wb_ready), 64'd1);
    chk("mid_cnt_after", commit_cnt, 64'd0);
    run(2, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
